// File: rtl/fp32_pkg.sv
// Shared FP32 types and constants for the TPU element-wise reducers.
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } fp32_t;

    localparam int BIAS = 127;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } poolState_t;

endpackage

// File: rtl/fp32_lt.sv
// Combinational sign-magnitude "less than" on raw FP32 bit patterns.
module fp32_lt
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);

    fp32_t       fa;
    fp32_t       fb;
    logic [30:0] magA;
    logic [30:0] magB;

    assign fa   = a;
    assign fb   = b;
    assign magA = {fa.exponent, fa.mantissa};
    assign magB = {fb.exponent, fb.mantissa};

    // Negative beats positive (so -0 < +0); among negatives the larger magnitude is smaller.
    always_comb begin
        if (fa.sign != fb.sign) begin
            lt = fa.sign;
        end else if (fa.sign) begin
            lt = magA > magB;
        end else begin
            lt = magA < magB;
        end
    end

endmodule

// File: rtl/fp32_min_pool.sv
// Streaming FP32 min-pool: running minimum over WINDOW elements (or up to in_last),
// one registered result per window over a valid/ready handshake.
module fp32_min_pool
    import fp32_pkg::*;
#(
    parameter  int WINDOW = 4,
    localparam int CW     = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [CW-1:0] out_count
);

    poolState_t    state;
    poolState_t    stateNext;
    logic [31:0]   acc;
    logic [31:0]   accNext;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNext;
    logic [31:0]   outData;
    logic [CW-1:0] outCount;
    logic          accept;
    logic          emit;
    logic          dataLess;

    fp32_lt uLt (
        .a  (in_data),
        .b  (acc),
        .lt (dataLess)
    );

    // Handshake depends only on state (and reset), never on the other side's valid/ready.
    assign in_ready  = !rst && (state != OUT);
    assign out_valid = !rst && (state == OUT);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign out_data  = outData;
    assign out_count = outCount;

    always_comb begin
        stateNext = state;
        accNext   = acc;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    accNext   = in_data;
                    cntNext   = CW'(1);
                    stateNext = (in_last || WINDOW == 1) ? OUT : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    accNext = dataLess ? in_data : acc;
                    cntNext = cnt + CW'(1);
                    if (in_last || cntNext == CW'(WINDOW)) begin
                        stateNext = OUT;
                    end
                end
            end
            OUT: begin
                if (emit) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            outData  <= '0;
            outCount <= '0;
        end else begin
            state <= stateNext;
            acc   <= accNext;
            cnt   <= cntNext;
            // Capture the result on the closing accept so it is held stable throughout OUT.
            if (state != OUT && stateNext == OUT) begin
                outData  <= accNext;
                outCount <= cntNext;
            end
        end
    end

endmodule

// File: tb/tb_fp32_min_pool.sv
// Self-checking bench for fp32_min_pool with WINDOW = 4, 1 and 256 instances.
module tb_fp32_min_pool;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid  [3];
    logic        inLast   [3];
    logic        outReady [3];
    logic        inReady  [3];
    logic        outValid [3];
    logic [31:0] inData   [3];
    logic [31:0] outData  [3];
    logic [8:0]  outCnt   [3];
    logic [2:0]  cnt4;
    logic [0:0]  cnt1;
    logic [8:0]  cnt256;

    int nAssert = 0;
    int nFail   = 0;

    logic [31:0] mMin [3];
    int          mCnt [3];
    logic [40:0] q0[$];
    logic [40:0] q1[$];
    logic [40:0] q2[$];

    always #5 clk = ~clk;

    assign outCnt[0] = {6'b0, cnt4};
    assign outCnt[1] = {8'b0, cnt1};
    assign outCnt[2] = cnt256;

    fp32_min_pool #(.WINDOW(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
        .in_last(inLast[0]), .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
        .out_count(cnt4)
    );
    fp32_min_pool #(.WINDOW(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
        .in_last(inLast[1]), .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
        .out_count(cnt1)
    );
    fp32_min_pool #(.WINDOW(256)) u256 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
        .in_last(inLast[2]), .out_valid(outValid[2]), .out_ready(outReady[2]), .out_data(outData[2]),
        .out_count(cnt256)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Order key: negatives map below every positive, -0 to -1, so a plain signed compare suffices.
    function automatic logic signed [32:0] orderKey(input logic [31:0] v);
        if (v[31]) return -$signed({2'b00, v[30:0]}) - 33'sd1;
        return $signed({2'b00, v[30:0]});
    endfunction

    function automatic int winOf(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 256;
    endfunction

    task automatic pushExp(input int k, input logic [40:0] e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic popExp(input int k, output logic [40:0] e);
        e = 'x;
        case (k)
            0: if (q0.size() > 0) e = q0.pop_front();
            1: if (q1.size() > 0) e = q1.pop_front();
            default: if (q2.size() > 0) e = q2.pop_front();
        endcase
    endtask

    task automatic send(input int k, input logic [31:0] d, input logic l);
        logic acc;
        acc = 1'b0;
        inValid[k] = 1'b1;
        inData[k]  = d;
        inLast[k]  = l;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = inReady[k];
            @(posedge clk);
            #1;
        end
        inValid[k] = 1'b0;
        inLast[k]  = 1'b0;
        checkBit("accept", acc, 1'b1);
        if (mCnt[k] == 0 || orderKey(d) < orderKey(mMin[k])) mMin[k] = d;
        mCnt[k]++;
        if (l || mCnt[k] == winOf(k)) begin
            pushExp(k, {9'(mCnt[k]), mMin[k]});
            mCnt[k] = 0;
        end
    endtask

    task automatic expectOut(input int k, input int budget, input string tag);
        logic [40:0] e;
        int w;
        w = 0;
        while (outValid[k] !== 1'b1 && w < budget) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkBit({tag, "_valid"}, outValid[k], 1'b1);
        popExp(k, e);
        check({tag, "_data"}, outData[k], e[31:0]);
        check({tag, "_count"}, {23'b0, outCnt[k]}, {23'b0, e[40:32]});
    endtask

    task automatic finishEmit(input int k, input string tag);
        @(posedge clk);
        #1;
        checkBit({tag, "_valid_drop"}, outValid[k], 1'b0);
        checkBit({tag, "_ready_back"}, inReady[k], 1'b1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [8:0]  heldCnt;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inValid[k]  = 1'b0;
            inLast[k]   = 1'b0;
            inData[k]   = 32'h0;
            outReady[k] = 1'b1;
            mMin[k]     = 32'h0;
            mCnt[k]     = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        checkBit("rst_in_ready", inReady[0], 1'b0);
        checkBit("rst_out_valid", outValid[0], 1'b0);
        check("rst_out_data", outData[0], 32'h0);
        check("rst_out_count", {23'b0, outCnt[2]}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkBit("idle_in_ready", inReady[0], 1'b1);
        checkBit("idle_out_valid", outValid[0], 1'b0);

        // Full window back-to-back: result one cycle after closing accept, valid for one cycle.
        send(0, 32'h40000000, 1'b0);
        send(0, 32'h3F800000, 1'b0);
        send(0, 32'h3F000000, 1'b0);
        send(0, 32'hC0400000, 1'b0);
        expectOut(0, 0, "full4");
        finishEmit(0, "full4");

        // Early termination, then a clean following window.
        send(0, 32'h40000000, 1'b0);
        send(0, 32'h3F000000, 1'b1);
        expectOut(0, 0, "last2");
        finishEmit(0, "last2");
        send(0, 32'h41000000, 1'b0);
        send(0, 32'h40800000, 1'b0);
        send(0, 32'h40400000, 1'b0);
        send(0, 32'h40A00000, 1'b0);
        expectOut(0, 0, "clean");
        finishEmit(0, "clean");

        // Negatives and signed zeros.
        send(0, 32'hBF000000, 1'b0);
        send(0, 32'hC0400000, 1'b0);
        send(0, 32'h00000000, 1'b0);
        send(0, 32'h80000000, 1'b0);
        expectOut(0, 0, "neg");
        finishEmit(0, "neg");
        send(0, 32'h00000000, 1'b0);
        send(0, 32'h80000000, 1'b1);
        expectOut(0, 0, "zeros");
        finishEmit(0, "zeros");

        // Back-pressure: result held, input refused even with a tempting -Inf offered.
        outReady[0] = 1'b0;
        send(0, 32'h3F800000, 1'b0);
        send(0, 32'hBF800000, 1'b0);
        send(0, 32'h7F800000, 1'b0);
        send(0, 32'h7FC00000, 1'b0);
        held    = q0[0][31:0];
        heldCnt = q0[0][40:32];
        inValid[0] = 1'b1;
        inData[0]  = 32'hFF800000;
        inLast[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkBit("bp_valid", outValid[0], 1'b1);
            checkBit("bp_in_ready", inReady[0], 1'b0);
            check("bp_data", outData[0], held);
            check("bp_count", {23'b0, outCnt[0]}, {23'b0, heldCnt});
        end
        inValid[0]  = 1'b0;
        inLast[0]   = 1'b0;
        outReady[0] = 1'b1;
        expectOut(0, 0, "bp");
        finishEmit(0, "bp");

        // Reset mid-window discards the partial result.
        send(0, 32'hC0400000, 1'b0);
        send(0, 32'hBF800000, 1'b0);
        checkBit("pre_rst_valid", outValid[0], 1'b0);
        rst = 1'b1;
        mCnt[0] = 0;
        @(posedge clk);
        #1;
        checkBit("in_rst_valid", outValid[0], 1'b0);
        rst = 1'b0;
        send(0, 32'h3F800000, 1'b0);
        send(0, 32'h40000000, 1'b0);
        send(0, 32'h3F000000, 1'b0);
        send(0, 32'h40000000, 1'b0);
        expectOut(0, 0, "post_rst");
        finishEmit(0, "post_rst");

        // WINDOW = 1 with random idle gaps and random in_last.
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(1, $urandom, 1'($urandom_range(0, 1)));
            expectOut(1, 0, "w1");
            finishEmit(1, "w1");
        end

        // WINDOW = 256 with random idle gaps.
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 256; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                send(2, $urandom, 1'b0);
            end
            expectOut(2, 0, "w256");
            finishEmit(2, "w256");
        end

        check("sb_leftover", 32'(q0.size() + q1.size() + q2.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/fp32_min_pool.md
# fp32_min_pool

Streaming FP32 min-pooling reducer that sits directly downstream of the TPU's element-wise FP32 datapath. It accepts one IEEE-754 single-precision value per cycle over a valid/ready handshake, keeps a running minimum over a window of `WINDOW` elements (or fewer, terminated by `in_last`), and emits one result per window over an output valid/ready handshake.

## Interface
- `WINDOW`, default 4: elements per pooling window; legal range 1..256.
- `CW`, default `$clog2(WINDOW+1)`: width of the element counter and `out_count`; derived, never overridden.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  `in_data` / `in_last` valid.
- `in_ready`  out  1  block accepts input this cycle.
- `in_data`  in  32  FP32 operand.
- `in_last`  in  1  accepted element closes the window early.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  32  FP32 minimum of the window.
- `out_count`  out  CW  number of elements reduced into `out_data`, 1..WINDOW.

## Operation
- Accept = `in_valid && in_ready`. Emit = `out_valid && out_ready`.
- FSM states:
  - IDLE: `in_ready`=1. On accept: `acc`=`in_data`, `cnt`=1. Go to OUT if `in_last` or `WINDOW`==1; otherwise go to ACC.
  - ACC: `in_ready`=1. On accept: `acc`=min(`acc`,`in_data`), `cnt`+=1. Go to OUT when the new `cnt`==`WINDOW` or `in_last`=1; both together have the same effect.
  - OUT: `in_ready`=0, `out_valid`=1, `out_data`=`acc`, `out_count`=`cnt`. On emit, go to IDLE.
- Ordering is sign-magnitude total order on the raw bit pattern:
  - Both signs 0: the smaller magnitude (`bits[30:0]`) is less.
  - Both signs 1: the larger magnitude is less.
  - Signs differ: the negative operand is less, so -0 (0x80000000) < +0 (0x00000000).
  - Equal patterns: keep `acc`.
- NaN/Inf/denormals are not special-cased. They are ordered by bit pattern as above.
- No arithmetic, rounding or normalisation: `out_data` is always bit-identical to one accepted input.
- `in_valid` gaps are legal in any state; FSM and `acc` hold.
- In OUT, `in_data`/`in_last` are ignored and `out_data` is held stable until emit.

## Timing
- Reset values while `rst`=1 and the cycle after: state IDLE, `in_ready`=0 during reset then 1, `out_valid`=0, `out_data`=0, `out_count`=0, `acc`=0, `cnt`=0.
- Reset mid-window or in OUT discards the partial or pending result with no emit.
- Latency: result is valid the cycle after the closing accept.
- Throughput: one element per cycle inside a window. There is at least one bubble per window (OUT cycle, `in_ready`=0), so the best case is `WINDOW`+1 cycles per window.
- `in_ready` depends on state only, never combinationally on `in_valid` or `out_ready`.
- `out_valid` must not drop without an emit, except on reset.
- `out_data` and `out_count` are registered.

## Structure
- Shared package `fp32_pkg`:
  - `fp32_t` packed struct {`sign`, `exponent[7:0]`, `mantissa[22:0]`}.
  - `BIAS` = 127.
  - Pool FSM state enum {IDLE, ACC, OUT}.
- Sub-module `fp32_lt`: combinational, `a`/`b` 32-bit in, `lt` out, implementing the ordering above. It is reusable by the max-pool and sort blocks.
- The top contains the FSM, the `acc`/`cnt` registers and the output registers.

## Test plan
- `WINDOW`=4, back-to-back 0x40000000, 0x3F800000, 0x3F000000, 0xC0400000, `out_ready`=1 → one emit: `out_data`=0xC0400000, `out_count`=4, `out_valid` high exactly 1 cycle, 5 cycles per window.
- `WINDOW`=4, 0x40000000 then 0x3F000000 with `in_last`=1 → `out_data`=0x3F000000, `out_count`=2. The following window starts clean.
- Negatives and zeros: window 0xBF000000, 0xC0400000, 0x00000000, 0x80000000 → 0xC0400000. A 2-element window 0x00000000, 0x80000000 with `in_last` → 0x80000000.
- Back-pressure: hold `out_ready`=0 for 5 cycles in OUT → `out_valid`=1, `out_data`/`out_count` stable, `in_ready`=0, `in_valid` ignored. On `out_ready`=1: emit, then IDLE and `in_ready`=1 next cycle.
- Reset mid-window: accept 0xC0400000, 0xBF800000, assert `rst` 1 cycle, then stream 0x3F800000, 0x40000000, 0x3F000000, 0x40000000 → `out_data`=0x3F000000, `out_count`=4. No emit before the reset.
- `in_valid` gaps (random 0–3 idle cycles) with `WINDOW`=1 and `WINDOW`=256 → every result matches a reference min model, and `out_count` equals `WINDOW`.
